// File: rtl/lab6_serial_rx_ctrl.sv
// Serial receiver front end for the lab 6 shift register.
// Synchronises an idle-high UART line, times each bit with a cycle counter and
// emits one sampled bit plus a one-cycle shift strobe at every data-bit midpoint.
module lab6_serial_rx_ctrl #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic data_in,
  output logic shift_en,
  output logic frame_done,
  output logic frame_err,
  output logic busy
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitsW = $clog2(WIDTH + 1);

  localparam logic [CntW-1:0]  HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0]  BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitsW-1:0] LastData = BitsW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e            state;
  logic              rx_meta;
  logic              rx_s;
  logic [CntW-1:0]   bit_cnt;
  logic [BitsW-1:0]  bits;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM with registered strobes; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      bit_cnt    <= '0;
      bits       <= '0;
      data_in    <= 1'b0;
      shift_en   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      shift_en   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (!rx_s) begin
            state   <= StStart;
            bit_cnt <= '0;
          end
        end
        StStart: begin
          if (bit_cnt == HalfLast) begin
            bit_cnt <= '0;
            if (!rx_s) begin
              state <= StData;
              bits  <= '0;
            end else begin
              // Start bit did not survive to its midpoint: treat as a glitch.
              state <= StIdle;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        StData: begin
          if (bit_cnt == BitLast) begin
            data_in  <= rx_s;
            shift_en <= 1'b1;
            bit_cnt  <= '0;
            bits     <= bits + 1'b1;
            if (bits == LastData) state <= StStop;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        StStop: begin
          if (bit_cnt == BitLast) begin
            bit_cnt <= '0;
            if (rx_s) begin
              frame_done <= 1'b1;
              state      <= StIdle;
            end else begin
              frame_err <= 1'b1;
              state     <= StWaitHigh;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        StWaitHigh: begin
          // A held-low line (break) must go high before a new start is accepted.
          if (rx_s) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign busy = (state != StIdle);

endmodule

// File: tb/tb_lab6_serial_rx_ctrl.sv
// Directed bench for lab6_serial_rx_ctrl: one 8-bit/16-clk instance and one
// 5-bit/4-clk instance, each feeding a model of the downstream shift register.
module tb_lab6_serial_rx_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic data_in_a, shift_en_a, done_a, err_a, busy_a;
  logic data_in_b, shift_en_b, done_b, err_b, busy_b;

  always #5 clk = ~clk;

  lab6_serial_rx_ctrl #(.WIDTH(8), .CLKS_PER_BIT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .data_in(data_in_a), .shift_en(shift_en_a),
    .frame_done(done_a), .frame_err(err_a), .busy(busy_a)
  );

  lab6_serial_rx_ctrl #(.WIDTH(5), .CLKS_PER_BIT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .data_in(data_in_b), .shift_en(shift_en_b),
    .frame_done(done_b), .frame_err(err_b), .busy(busy_b)
  );

  int total = 0;
  int bad = 0;

  // Downstream shift register models and event counters.
  logic [7:0] sr_a = '0;
  logic [4:0] sr_b = '0;
  logic [7:0] words_a[$];
  int se_cnt_a, done_cnt_a, err_cnt_a, busy_rise_a, busy_hi_a, ovl_cnt;
  int se_cnt_b, done_cnt_b;
  logic busy_prev_a = 1'b0, busy_prev_b = 1'b0;
  int cyc = 0;
  int start_b = 0;
  int stb_off_b[$];
  int done_off_b = -1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (shift_en_a) begin
      se_cnt_a++;
      sr_a = {data_in_a, sr_a[7:1]};
    end
    if (done_a) begin
      done_cnt_a++;
      words_a.push_back(sr_a);
    end
    if (err_a) err_cnt_a++;
    if (busy_a && !busy_prev_a) busy_rise_a++;
    if (busy_a) busy_hi_a++;
    if ((shift_en_a && (done_a || err_a)) || (done_a && err_a)) ovl_cnt++;
    if ((shift_en_b && (done_b || err_b)) || (done_b && err_b)) ovl_cnt++;
    busy_prev_a = busy_a;
    if (busy_b && !busy_prev_b) start_b = cyc;
    if (shift_en_b) begin
      se_cnt_b++;
      sr_b = {data_in_b, sr_b[4:1]};
      stb_off_b.push_back(cyc - start_b);
    end
    if (done_b) begin
      done_cnt_b++;
      done_off_b = cyc - start_b;
    end
    busy_prev_b = busy_b;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_counts();
    @(posedge clk);
    se_cnt_a = 0; done_cnt_a = 0; err_cnt_a = 0; busy_rise_a = 0; busy_hi_a = 0;
    se_cnt_b = 0; done_cnt_b = 0;
    words_a.delete();
    stb_off_b.delete();
    done_off_b = -1;
  endtask

  task automatic set_rx(input bit which, input logic v);
    if (which) rx_b = v;
    else rx_a = v;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start bit plus data bits LSB first; the stop bit is left to the caller.
  task automatic send_data(input bit which, input logic [7:0] d, input int nbits, input int cpb);
    set_rx(which, 1'b0);
    hold(cpb);
    for (int i = 0; i < nbits; i++) begin
      set_rx(which, d[i]);
      hold(cpb);
    end
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input int nbits,
                            input int cpb);
    send_data(which, d, nbits, cpb);
    set_rx(which, 1'b1);
    hold(cpb);
  endtask

  typedef struct {
    logic [7:0] data;
    int         strobes;
    int         done;
    int         err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{data: 8'hA5, strobes: 8, done: 1, err: 0};
    vecs[1] = '{data: 8'h00, strobes: 8, done: 1, err: 0};
    vecs[2] = '{data: 8'hFF, strobes: 8, done: 1, err: 0};
    vecs[3] = '{data: 8'h3C, strobes: 8, done: 1, err: 0};
    vecs[4] = '{data: 8'h81, strobes: 8, done: 1, err: 0};

    // Reset state
    hold(3);
    check("rst_data_in", int'(data_in_a), 0);
    check("rst_shift_en", int'(shift_en_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_err", int'(err_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_busy_b", int'(busy_b), 0);
    rst_n = 1'b1;
    hold(4);

    // Table-driven well-formed frames
    for (int v = 0; v < 5; v++) begin
      clear_counts();
      send_frame(1'b0, vecs[v].data, 8, 16);
      hold(16);
      check($sformatf("vec%0d_strobes", v), se_cnt_a, vecs[v].strobes);
      check($sformatf("vec%0d_done", v), done_cnt_a, vecs[v].done);
      check($sformatf("vec%0d_err", v), err_cnt_a, vecs[v].err);
      check($sformatf("vec%0d_word", v), int'(sr_a), int'(vecs[v].data));
      check($sformatf("vec%0d_busy_end", v), int'(busy_a), 0);
    end

    // Glitch: 5 low cycles must abort at the start midpoint
    clear_counts();
    @(negedge clk);
    rx_a = 1'b0;
    hold(5);
    rx_a = 1'b1;
    hold(20);
    check("glitch_strobes", se_cnt_a, 0);
    check("glitch_busy_cycles", busy_hi_a, 8);
    check("glitch_busy_end", int'(busy_a), 0);
    check("glitch_done", done_cnt_a + err_cnt_a, 0);

    // Framing error with the line held low afterwards
    clear_counts();
    send_data(1'b0, 8'h5A, 8, 16);
    rx_a = 1'b0;
    hold(40);
    check("ferr_strobes", se_cnt_a, 8);
    check("ferr_err", err_cnt_a, 1);
    check("ferr_done", done_cnt_a, 0);
    check("ferr_word", int'(sr_a), 8'h5A);
    check("ferr_busy_low_line", int'(busy_a), 1);
    check("ferr_no_restart", busy_rise_a, 1);
    rx_a = 1'b1;
    @(negedge clk);
    check("ferr_busy_after_1", int'(busy_a), 1);
    hold(2);
    check("ferr_busy_after_3", int'(busy_a), 0);
    hold(10);

    // Reset during the 0xFF frame after its 3rd strobe
    clear_counts();
    @(negedge clk);
    rx_a = 1'b0;
    hold(16);
    rx_a = 1'b1;
    for (int i = 0; i < 200 && se_cnt_a < 3; i++) @(negedge clk);
    check("rstmid_reached_3", se_cnt_a, 3);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_data_in", int'(data_in_a), 0);
    check("rstmid_busy", int'(busy_a), 0);
    check("rstmid_shift_en", int'(shift_en_a), 0);
    hold(3);
    rst_n = 1'b1;
    hold(30);
    check("rstmid_no_pulse", done_cnt_a + err_cnt_a, 0);
    clear_counts();
    send_frame(1'b0, 8'h3C, 8, 16);
    hold(16);
    check("rstmid_3c_strobes", se_cnt_a, 8);
    check("rstmid_3c_done", done_cnt_a, 1);
    check("rstmid_3c_word", int'(sr_a), 8'h3C);

    // Back-to-back frames with no idle gap
    clear_counts();
    send_frame(1'b0, 8'h00, 8, 16);
    send_frame(1'b0, 8'hFF, 8, 16);
    hold(16);
    check("b2b_done", done_cnt_a, 2);
    check("b2b_strobes", se_cnt_a, 16);
    check("b2b_words", words_a.size(), 2);
    if (words_a.size() == 2) begin
      check("b2b_word0", int'(words_a[0]), 8'h00);
      check("b2b_word1", int'(words_a[1]), 8'hFF);
    end

    // Narrow instance: 5 bits at 4 clocks per bit, exact timing
    clear_counts();
    send_frame(1'b1, 8'h13, 5, 4);
    hold(12);
    check("b_strobes", se_cnt_b, 5);
    for (int k = 0; k < 5; k++) begin
      if (k < stb_off_b.size())
        check($sformatf("b_strobe%0d_cycle", k), stb_off_b[k], 6 + 4 * k);
    end
    check("b_done", done_cnt_b, 1);
    check("b_done_cycle", done_off_b, 26);
    check("b_word", int'(sr_b), 5'h13);

    check("pulse_overlap", ovl_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
